// File: rtl/pipe_stage_skid_pkg.sv
// Shared payload layout and widths for the pipeline-boundary skid stage.
// Each stage boundary packs its own fields into the DATA_W payload at the instantiation site.
package pipe_stage_skid_pkg;

    localparam int unsigned DATA_FIELD_W = 32;
    localparam int unsigned REG_IDX_W    = 6;
    localparam int unsigned WB_CTRL_W    = 3;
    localparam int unsigned MEM_CTRL_W   = 2;

    typedef struct packed {
        logic [DATA_FIELD_W-1:0] alu_result;
        logic [DATA_FIELD_W-1:0] store_data;
        logic [DATA_FIELD_W-1:0] branch_target;
        logic [REG_IDX_W-1:0]    rd;
        logic [WB_CTRL_W-1:0]    wb_ctrl;
        logic [MEM_CTRL_W-1:0]   mem_ctrl;
    } stage_payload_t;

    localparam int unsigned DEFAULT_DATA_W = $bits(stage_payload_t);

endpackage

// File: rtl/pipe_stage_skid.sv
// Two-entry (main + skid) pipeline register with registered in_ready, flush and a
// saturating backpressure counter; captures on the clock edge chosen by NEG_EDGE.
module pipe_stage_skid
    import pipe_stage_skid_pkg::*;
#(
    parameter int unsigned DATA_W   = DEFAULT_DATA_W,
    parameter bit          NEG_EDGE = 1'b1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [CNT_W-1:0] CntMax = '1;

    logic              cap_clk;
    logic              main_valid_q, main_valid_d;
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CNT_W-1:0]  stall_q, stall_d;

    assign cap_clk = NEG_EDGE ? ~clk : clk;

    always_comb begin
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_data_d  = main_data_q;
        skid_data_d  = skid_data_q;
        stall_d      = stall_q;

        if (main_valid_q && !out_ready && stall_q != CntMax) begin
            stall_d = stall_q + 1'b1;
        end

        // Flush drops valid bits only; data registers keep their stale contents.
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (skid_valid_q) begin
            // in_ready is low here, so only the drain of skid into main can happen.
            if (out_ready) begin
                main_data_d  = skid_data_q;
                skid_valid_d = 1'b0;
            end
        end else if (main_valid_q) begin
            if (in_valid && out_ready) begin
                main_data_d = in_data;
            end else if (in_valid) begin
                skid_data_d  = in_data;
                skid_valid_d = 1'b1;
            end else if (out_ready) begin
                main_valid_d = 1'b0;
            end
        end else if (in_valid) begin
            main_valid_d = 1'b1;
            main_data_d  = in_data;
        end
    end

    always_ff @(posedge cap_clk or posedge rst) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_data_q  <= '0;
            skid_data_q  <= '0;
            stall_q      <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_data_q  <= main_data_d;
            skid_data_q  <= skid_data_d;
            stall_q      <= stall_d;
        end
    end

    assign in_ready  = ~skid_valid_q;
    assign out_valid = main_valid_q;
    assign out_data  = main_data_q;
    assign occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};
    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench: a falling-edge instance and a rising-edge (4-bit counter) instance share
// stimulus; a 2-deep FIFO model feeds expected payloads to a monitor that checks both.
module tb_pipe_stage_skid;
    import pipe_stage_skid_pkg::*;

    localparam int unsigned DW   = DEFAULT_DATA_W;
    localparam int unsigned CW_N = 16;
    localparam int unsigned CW_P = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic          flush = 1'b0;
    logic [DW-1:0] in_data = '0;

    logic            in_ready_n, out_valid_n, in_ready_p, out_valid_p;
    logic [DW-1:0]   out_data_n, out_data_p;
    logic [1:0]      occ_n, occ_p;
    logic [CW_N-1:0] stall_n;
    logic [CW_P-1:0] stall_p;

    always #5 clk = ~clk;

    pipe_stage_skid #(.DATA_W(DW), .NEG_EDGE(1'b1), .CNT_W(CW_N)) dut_n (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_n), .in_data(in_data),
        .flush(flush), .out_valid(out_valid_n), .out_ready(out_ready), .out_data(out_data_n),
        .occupancy(occ_n), .stall_cnt(stall_n)
    );

    pipe_stage_skid #(.DATA_W(DW), .NEG_EDGE(1'b0), .CNT_W(CW_P)) dut_p (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_p), .in_data(in_data),
        .flush(flush), .out_valid(out_valid_p), .out_ready(out_ready), .out_data(out_data_p),
        .occupancy(occ_p), .stall_cnt(stall_p)
    );

    int            checks = 0;
    int            failures = 0;
    logic [DW-1:0] exp_q[$];
    int            held = 0;
    int            exp_occ = 0;
    int            stall_m_n = 0, stall_m_p = 0;
    int            exp_stall_n = 0, exp_stall_p = 0;
    bit            mon_en = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // One cycle: drive inputs just after the rising edge and advance the FIFO model.
    // Both instances see these inputs at their next capture edge.
    task automatic step(input logic iv, input logic [DW-1:0] d, input logic ordy,
                        input logic fl);
        int pre;
        @(posedge clk);
        #1;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        pre         = held;
        exp_occ     = pre;
        exp_stall_n = stall_m_n;
        exp_stall_p = stall_m_p;
        if (pre > 0 && !ordy) begin
            if (stall_m_n < 2 ** CW_N - 1) stall_m_n++;
            if (stall_m_p < 2 ** CW_P - 1) stall_m_p++;
        end
        if (fl) begin
            exp_q.delete();
            held = 0;
        end else begin
            if (pre > 0 && ordy) held--;
            if (iv && pre < 2) begin
                held++;
                exp_q.push_back(d);
            end
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        held        = 0;
        exp_occ     = 0;
        stall_m_n   = 0;
        stall_m_p   = 0;
        exp_stall_n = 0;
        exp_stall_p = 0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_occ_n"}, 128'(occ_n), 128'(0));
        chk({tag, "_occ_p"}, 128'(occ_p), 128'(0));
        chk({tag, "_out_valid_n"}, 128'(out_valid_n), 128'(0));
        chk({tag, "_out_valid_p"}, 128'(out_valid_p), 128'(0));
        chk({tag, "_in_ready_n"}, 128'(in_ready_n), 128'(1));
        chk({tag, "_in_ready_p"}, 128'(in_ready_p), 128'(1));
        chk({tag, "_stall_n"}, 128'(stall_n), 128'(0));
        chk({tag, "_stall_p"}, 128'(stall_p), 128'(0));
        chk({tag, "_out_data_n"}, 128'(out_data_n), 128'(0));
        chk({tag, "_out_data_p"}, 128'(out_data_p), 128'(0));
    endtask

    // Monitor: state seen here is the result of all earlier edges, inputs are this cycle's.
    always @(posedge clk) begin
        #2;
        if (mon_en) begin
            chk("occupancy_n", 128'(occ_n), 128'(exp_occ));
            chk("occupancy_p", 128'(occ_p), 128'(exp_occ));
            chk("out_valid_n", 128'(out_valid_n), 128'(exp_occ > 0));
            chk("out_valid_p", 128'(out_valid_p), 128'(exp_occ > 0));
            chk("in_ready_n", 128'(in_ready_n), 128'(exp_occ < 2));
            chk("in_ready_p", 128'(in_ready_p), 128'(exp_occ < 2));
            chk("stall_cnt_n", 128'(stall_n), 128'(exp_stall_n));
            chk("stall_cnt_p", 128'(stall_p), 128'(exp_stall_p));
            if (exp_occ > 0 && out_ready && !flush) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL scoreboard_empty actual=transfer required=none at %0t", $time);
                end else begin
                    chk("out_data_n", 128'(out_data_n), 128'(exp_q[0]));
                    chk("out_data_p", 128'(out_data_p), 128'(exp_q[0]));
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        logic [127:0] r;

        #1 rst = 1'b1;
        #2 check_reset_state("init_reset");
        #5 rst = 1'b0;
        mon_en = 1'b1;

        // Streaming 1..8; the falling-edge instance must capture half a cycle earlier.
        step(1'b1, DW'(1), 1'b1, 1'b0);
        @(negedge clk);
        #1;
        chk("neg_edge_captured", 128'(out_valid_n), 128'(1));
        chk("pos_edge_not_yet", 128'(out_valid_p), 128'(0));
        for (int i = 2; i <= 8; i++) step(1'b1, DW'(i), 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);

        // Backpressure: 0xA held, 0xB goes to skid, then both drain in order.
        step(1'b1, DW'('hA), 1'b0, 1'b0);
        step(1'b1, DW'('hB), 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        chk("bp_occ_full", 128'(occ_p), 128'(2));
        chk("bp_in_ready_low", 128'(in_ready_p), 128'(0));
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);

        // Flush while full, with a coincident input that must be discarded.
        step(1'b1, DW'(1), 1'b0, 1'b0);
        step(1'b1, DW'(2), 1'b0, 1'b0);
        step(1'b1, DW'('hC), 1'b0, 1'b1);
        step(1'b1, DW'('hD), 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);

        // Saturation of the 4-bit counter, held through a flush.
        step(1'b1, DW'(5), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0);
        chk("sat_after_flush_p", 128'(stall_p), 128'(15));

        // Asynchronous reset mid-cycle with both entries held.
        step(1'b1, DW'('h11), 1'b0, 1'b0);
        step(1'b1, DW'('h22), 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        #2;
        mon_en = 1'b0;
        rst = 1'b1;
        #1 check_reset_state("async_reset");
        model_reset();
        @(posedge clk);
        #3 rst = 1'b0;
        mon_en = 1'b1;

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            r = {$urandom(), $urandom(), $urandom(), $urandom()};
            step(1'($urandom_range(0, 9) < 7), r[DW-1:0], 1'($urandom_range(0, 9) < 6),
                 1'($urandom_range(0, 99) < 3));
        end
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        #4;
        mon_en = 1'b0;
        chk("drained", 128'(exp_q.size()), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
